// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, FSM encoding, instruction field positions.
// Pure types and constants, no logic or latency.
// No flow control here; users own handshaking.
package decode_stage_pkg;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_LDD = 5'b10010;

    // Instruction word layout
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;
    // opcode bit that announces a trailing immediate word
    localparam int OPC_IMM_BIT = 4;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  opcode;
        logic [2:0]  rdst;
        logic [2:0]  rs1_add;
        logic [2:0]  rs2_add;
        logic [15:0] rs1_data;
        logic [15:0] rs2_data;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        mem_read;
        logic        writes_rd;
    } idex_t;

    function automatic logic [4:0] fld_opc(input logic [15:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] fld_rd(input logic [15:0] w);
        return w[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [2:0] fld_rs1(input logic [15:0] w);
        return w[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [2:0] fld_rs2(input logic [15:0] w);
        return w[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Opcode to control-bit decoder.
// Purely combinational, zero latency.
// No backpressure; unknown opcodes decode as NOP controls.
module decode_ctrl
    import decode_stage_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       writes_rd_o,
    output logic       mem_read_o,
    output logic       has_imm_o
);

    // Control table; the immediate flag follows the opcode bit for every opcode
    always_comb begin
        uses_rs1_o  = 1'b0;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        mem_read_o  = 1'b0;
        has_imm_o   = opcode_i[OPC_IMM_BIT];
        case (opcode_i)
            OP_ADD: begin
                uses_rs1_o  = 1'b1;
                uses_rs2_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_LDD: begin
                uses_rs1_o  = 1'b1;
                writes_rd_o = 1'b1;
                mem_read_o  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits 1/2-word instructions, reads the RF, fills the ID/EX register.
// Latency 1 cycle from the last instruction word to ID/EX valid.
// Load-use hazard raises if_stall for one cycle and inserts a bubble; flush wins.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    input  logic        flush,
    output logic        if_stall,
    output logic [2:0]  rf_rd_add_1,
    output logic [2:0]  rf_rd_add_2,
    input  logic [15:0] rf_rd_data_1,
    input  logic [15:0] rf_rd_data_2,
    output logic        idex_valid,
    output logic [4:0]  idex_opcode,
    output logic [2:0]  idex_rdst,
    output logic [2:0]  idex_rs1_add,
    output logic [2:0]  idex_rs2_add,
    output logic [15:0] idex_rs1_data,
    output logic [15:0] idex_rs2_data,
    output logic [15:0] idex_imm,
    output logic [15:0] idex_pc,
    output logic        idex_mem_read,
    output logic        idex_writes_rd
);

    state_t      state_q, state_d;
    logic [15:0] hold_word_q, hold_word_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    idex_t       idex_q, idex_d;

    logic [15:0] cur_word;
    logic [15:0] cur_pc;
    logic [15:0] cur_imm;
    logic        uses_rs1, uses_rs2, writes_rd, mem_read, has_imm;
    logic        hazard;
    logic        issue;

    // In S_IMM the held opcode word is the instruction being decoded
    always_comb begin
        cur_word    = (state_q == S_IMM) ? hold_word_q : if_instr;
        cur_pc      = (state_q == S_IMM) ? hold_pc_q   : if_pc;
        cur_imm     = (state_q == S_IMM) ? if_instr    : 16'h0000;
        rf_rd_add_1 = fld_rs1(cur_word);
        rf_rd_add_2 = fld_rs2(cur_word);
    end

    decode_ctrl u_ctrl (
        .opcode_i    (fld_opc(cur_word)),
        .uses_rs1_o  (uses_rs1),
        .uses_rs2_o  (uses_rs2),
        .writes_rd_o (writes_rd),
        .mem_read_o  (mem_read),
        .has_imm_o   (has_imm)
    );

    // Load-use hazard against the load sitting in ID/EX; no bypass exists
    always_comb begin
        hazard   = (state_q == S_OP) && if_valid && idex_q.valid && idex_q.mem_read &&
                   ((uses_rs1 && (fld_rs1(cur_word) == idex_q.rdst)) ||
                    (uses_rs2 && (fld_rs2(cur_word) == idex_q.rdst)));
        if_stall = hazard && !flush && !reset;
        issue    = if_valid && !flush &&
                   ((state_q == S_IMM) || (!hazard && !has_imm));
    end

    // Next-state: default is a bubble with ID/EX fields retained
    always_comb begin
        state_d      = state_q;
        hold_word_d  = hold_word_q;
        hold_pc_d    = hold_pc_q;
        idex_d       = idex_q;
        idex_d.valid = 1'b0;
        if (flush) begin
            state_d     = S_OP;
            hold_word_d = 16'h0000;
            hold_pc_d   = 16'h0000;
        end else if (issue) begin
            idex_d = '{valid:     1'b1,
                       opcode:    fld_opc(cur_word),
                       rdst:      fld_rd(cur_word),
                       rs1_add:   fld_rs1(cur_word),
                       rs2_add:   fld_rs2(cur_word),
                       rs1_data:  rf_rd_data_1,
                       rs2_data:  rf_rd_data_2,
                       imm:       cur_imm,
                       pc:        cur_pc,
                       mem_read:  mem_read,
                       writes_rd: writes_rd};
            state_d = S_OP;
        end else if (if_valid && (state_q == S_OP) && !hazard && has_imm) begin
            hold_word_d = if_instr;
            hold_pc_d   = if_pc;
            state_d     = S_IMM;
        end
    end

    // State and pipeline registers; reset dominates everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_OP;
            hold_word_q <= 16'h0000;
            hold_pc_q   <= 16'h0000;
            idex_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_word_q <= hold_word_d;
            hold_pc_q   <= hold_pc_d;
            idex_q      <= idex_d;
        end
    end

    assign idex_valid     = idex_q.valid;
    assign idex_opcode    = idex_q.opcode;
    assign idex_rdst      = idex_q.rdst;
    assign idex_rs1_add   = idex_q.rs1_add;
    assign idex_rs2_add   = idex_q.rs2_add;
    assign idex_rs1_data  = idex_q.rs1_data;
    assign idex_rs2_data  = idex_q.rs2_data;
    assign idex_imm       = idex_q.imm;
    assign idex_pc        = idex_q.pc;
    assign idex_mem_read  = idex_q.mem_read;
    assign idex_writes_rd = idex_q.writes_rd;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: reference model predicts issued instructions and stalls.
// Checks issue timing (exactly one cycle after the completing word) and all ID/EX fields.
// Fetch holds its word while a stall is predicted.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, if_valid, flush;
    logic [15:0] if_instr, if_pc;
    logic        if_stall;
    logic [2:0]  rf_rd_add_1, rf_rd_add_2;
    logic [15:0] rf_rd_data_1, rf_rd_data_2;
    logic        idex_valid, idex_mem_read, idex_writes_rd;
    logic [4:0]  idex_opcode;
    logic [2:0]  idex_rdst, idex_rs1_add, idex_rs2_add;
    logic [15:0] idex_rs1_data, idex_rs2_data, idex_imm, idex_pc;

    logic [15:0] regs [0:7];
    assign rf_rd_data_1 = regs[rf_rd_add_1];
    assign rf_rd_data_2 = regs[rf_rd_add_2];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .if_stall(if_stall), .rf_rd_add_1(rf_rd_add_1), .rf_rd_add_2(rf_rd_add_2),
        .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2), .idex_valid(idex_valid),
        .idex_opcode(idex_opcode), .idex_rdst(idex_rdst), .idex_rs1_add(idex_rs1_add),
        .idex_rs2_add(idex_rs2_add), .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
        .idex_imm(idex_imm), .idex_pc(idex_pc), .idex_mem_read(idex_mem_read),
        .idex_writes_rd(idex_writes_rd)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] d1, d2, imm, pc;
        logic        mr, wr;
    } exp_t;

    exp_t exp_q [$];
    int   cyc_q [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: pending first word, and what the last cycle put into ID/EX
    logic        m_pend = 1'b0;
    logic [15:0] m_pw = '0, m_pp = '0;
    logic        m_lv = 1'b0, m_lmr = 1'b0;
    logic [2:0]  m_lrd = '0;
    logic        m_stall = 1'b0;

    localparam logic [4:0] ADD = 5'b00100;
    localparam logic [4:0] LDD = 5'b10010;

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] s1, input logic [2:0] s2);
        return {op, rd, s1, s2, 2'b00};
    endfunction

    // Instruction-set table: ADD reads both sources, LDD reads rs1 and loads
    function automatic void mdec(input logic [4:0] op, output logic u1, output logic u2,
                                 output logic wr, output logic mr);
        u1 = 1'b0; u2 = 1'b0; wr = 1'b0; mr = 1'b0;
        if (op == ADD) begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
        if (op == LDD) begin u1 = 1'b1; wr = 1'b1; mr = 1'b1; end
    endfunction

    // One fetch cycle: drive, predict, check stall, wait for the edge
    task automatic step(input logic v, input logic [15:0] w, input logic [15:0] p,
                        input logic fl, input logic rst);
        logic u1, u2, wr, mr, hz;
        logic [15:0] cw, cp;
        exp_t e;
        @(negedge clk);
        reset = rst; flush = fl; if_valid = v; if_instr = w; if_pc = p;
        #1;
        m_stall = 1'b0;
        if (rst) begin
            m_pend = 1'b0; m_lv = 1'b0; m_lmr = 1'b0; m_lrd = '0;
        end else if (fl) begin
            m_pend = 1'b0; m_lv = 1'b0;
        end else if (!v) begin
            m_lv = 1'b0;
        end else begin
            cw = m_pend ? m_pw : w;
            cp = m_pend ? m_pp : p;
            mdec(cw[15:11], u1, u2, wr, mr);
            hz = !m_pend && m_lv && m_lmr &&
                 ((u1 && cw[7:5] == m_lrd) || (u2 && cw[4:2] == m_lrd));
            if (hz) begin
                m_stall = 1'b1; m_lv = 1'b0;
            end else if (!m_pend && cw[15]) begin
                m_pend = 1'b1; m_pw = w; m_pp = p; m_lv = 1'b0;
            end else begin
                e = '{op: cw[15:11], rd: cw[10:8], rs1: cw[7:5], rs2: cw[4:2],
                      d1: regs[cw[7:5]], d2: regs[cw[4:2]],
                      imm: (m_pend ? w : 16'h0000), pc: cp, mr: mr, wr: wr};
                exp_q.push_back(e);
                cyc_q.push_back(cyc + 1);
                m_lv = 1'b1; m_lmr = mr; m_lrd = cw[10:8]; m_pend = 1'b0;
            end
        end
        checks++;
        if (if_stall !== m_stall) begin
            errors++;
            $display("FAIL if_stall cyc=%0d got=%b want=%b", cyc, if_stall, m_stall);
        end
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it while a stall is predicted (bounded)
    task automatic send(input logic [15:0] w, input logic [15:0] p);
        step(1'b1, w, p, 1'b0, 1'b0);
        for (int k = 0; k < 3 && m_stall; k++) step(1'b1, w, p, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if ({idex_valid, idex_opcode, idex_rdst, idex_rs1_add, idex_rs2_add, idex_rs1_data,
             idex_rs2_data, idex_imm, idex_pc, idex_mem_read, idex_writes_rd} !== '0) begin
            errors++;
            $display("FAIL %s got valid=%b op=%h rd=%h imm=%h pc=%h want all zero", tag,
                     idex_valid, idex_opcode, idex_rdst, idex_imm, idex_pc);
        end
    endtask

    // Monitor: every ID/EX valid must match the oldest prediction at its cycle
    initial begin
        exp_t e, o;
        int   c;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (idex_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue cyc=%0d got op=%h pc=%h want none", cyc,
                             idex_opcode, idex_pc);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    o = '{op: idex_opcode, rd: idex_rdst, rs1: idex_rs1_add, rs2: idex_rs2_add,
                          d1: idex_rs1_data, d2: idex_rs2_data, imm: idex_imm, pc: idex_pc,
                          mr: idex_mem_read, wr: idex_writes_rd};
                    if (o !== e || c != cyc) begin
                        errors++;
                        $display("FAIL idex cyc=%0d(want %0d) got=%h want=%h", cyc, c, o, e);
                    end
                end
            end else if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_issue cyc=%0d want pc=%h", cyc, exp_q[0].pc);
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] w;
        logic [15:0] pc;
        logic        v, fl, rs;
        reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);

        // Reset with a hazard-looking word present: stall must stay low
        step(1'b1, mk(ADD, 3'd1, 3'd2, 3'd3), 16'h0000, 1'b0, 1'b1);
        step(1'b1, mk(ADD, 3'd1, 3'd2, 3'd3), 16'h0000, 1'b1, 1'b1);
        check_reset_state("reset_state");

        // ADD R1,R2,R3
        regs[2] = 16'h1234; regs[3] = 16'h0011;
        send(mk(ADD, 3'd1, 3'd2, 3'd3), 16'h0040);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // LDD R4,R2 + imm, then dependent ADD R5,R4,R1 stalls once
        send(mk(LDD, 3'd4, 3'd2, 3'd0), 16'h0050);
        send(16'h0008, 16'h0051);
        send(mk(ADD, 3'd5, 3'd4, 3'd1), 16'h0052);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset while in S_IMM, then a normal ADD
        send(mk(LDD, 3'd4, 3'd2, 3'd0), 16'h0060);
        step(1'b1, 16'h0009, 16'h0061, 1'b0, 1'b1);
        check_reset_state("reset_mid_imm");
        send(mk(ADD, 3'd6, 3'd1, 3'd2), 16'h0062);

        // Flush in S_IMM; next word must decode as an opcode
        send(mk(LDD, 3'd3, 3'd1, 3'd0), 16'h0070);
        step(1'b1, 16'h0123, 16'h0071, 1'b1, 1'b0);
        send(mk(ADD, 3'd2, 3'd3, 3'd4), 16'h0080);

        // Flush coinciding with a load-use hazard: no stall
        send(mk(LDD, 3'd4, 3'd2, 3'd0), 16'h0090);
        send(16'h0004, 16'h0091);
        step(1'b1, mk(ADD, 3'd5, 3'd4, 3'd1), 16'h0092, 1'b1, 1'b0);

        // Same-cycle writeback of R2 seen by the reading ADD
        regs[2] = 16'hBEEF;
        send(mk(ADD, 3'd7, 3'd2, 3'd6), 16'h00A0);
        // Undefined opcode still propagates
        send(mk(5'b01011, 3'd1, 3'd2, 3'd3), 16'h00A2);

        // Randomised traffic
        pc = 16'h0100;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
            if (!m_stall) begin
                case ($urandom_range(0, 4))
                    0, 1: w = mk(ADD, 3'($urandom), 3'($urandom), 3'($urandom));
                    2:    w = mk(LDD, 3'($urandom), 3'($urandom), 3'($urandom));
                    3:    w = mk(5'b00000, 3'($urandom), 3'($urandom), 3'($urandom));
                    default: w = 16'($urandom);
                endcase
                pc = pc + 16'd1;
                v  = ($urandom_range(0, 4) != 0);
            end else begin
                v = 1'b1;
            end
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 79) == 0);
            step(v, w, pc, fl, rs);
        end

        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (posedge), reset (synchronous, active-high).
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  clock; all state on posedge
- reset  in  1  synchronous active-high reset
- if_valid  in  1  if_instr/if_pc hold a fetched word
- if_instr  in  16  fetched word (opcode or immediate)
- if_pc  in  16  PC of if_instr
- flush  in  1  branch taken; discard decode contents
- if_stall  out  1  fetch must hold its current word
- rf_rd_add_1 / rf_rd_add_2  out  3  register-file read addresses
- rf_rd_data_1 / rf_rd_data_2  in  16  register-file read data, valid before next posedge
- idex_valid  out  1  ID/EX holds a real instruction
- idex_opcode  out  5  ID/EX fields
- idex_rdst / idex_rs1_add / idex_rs2_add  out  3  ID/EX fields
- idex_rs1_data / idex_rs2_data / idex_imm / idex_pc  out  16  ID/EX fields
- idex_mem_read / idex_writes_rd  out  1  decoded controls

Function
REQ-003 Instruction fields SHALL be opcode=[15:11], rdst=[10:8], rs1=[7:5], rs2=[4:2]; opcode[4]=1 means a second immediate word follows.
REQ-004 The FSM SHALL have states S_OP (expect opcode word) and S_IMM (expect immediate word).
REQ-005 In S_OP, rf_rd_add_1/2 SHALL equal if_instr rs1/rs2; in S_IMM they SHALL equal the held rs1/rs2.
REQ-006 There SHALL be no internal write bypass; register-file write-before-read within a cycle is relied upon.
REQ-007 Hazard SHALL be: state S_OP & if_valid & idex_valid & idex_mem_read & ((uses_rs1 & rs1==idex_rdst) | (uses_rs2 & rs2==idex_rdst)).
REQ-008 On hazard: if_stall=1 combinationally, and the next ID/EX SHALL be a bubble (idex_valid=0, other fields unchanged); state stays S_OP.
REQ-009 In S_OP with if_valid, no hazard, and opcode[4]=0: ID/EX SHALL load all fields with idex_valid=1 and idex_imm=0 at the next edge (latency 1).
REQ-010 In S_OP with if_valid, no hazard, and opcode[4]=1: the block SHALL hold opcode/rdst/rs1/rs2/pc, go to S_IMM, and make ID/EX a bubble.
REQ-011 In S_IMM with if_valid: ID/EX SHALL load the held fields plus register data sampled this cycle and idex_imm=if_instr, with valid=1; state returns to S_OP.
REQ-012 In any state with if_valid=0: the next ID/EX SHALL be a bubble and the state SHALL be unchanged.
REQ-013 flush=1 SHALL take priority over everything: next idex_valid=0, state S_OP, if_stall=0, and the held word discarded.
REQ-014 if_stall SHALL be 0 in S_IMM; a stall never spans more than one cycle per hazard instance.
REQ-015 Undefined opcodes SHALL decode as NOP (uses none, writes none, mem_read=0) but SHALL still propagate with valid=1.

Reset
REQ-016 reset SHALL be synchronous and SHALL dominate flush and every other input.
REQ-017 At reset: idex_valid=0, all idex_* fields=0, state S_OP, held registers=0.
REQ-018 At reset: if_stall SHALL be 0 while reset is asserted.

Structure
REQ-019 The shared package SHALL hold opcode constants (NOP=5'b00000, ADD=5'b00100, LDD=5'b10010), FSM state encoding, and field-position constants.
REQ-020 A combinational sub-module decode_ctrl SHALL map opcode to uses_rs1, uses_rs2, writes_rd, mem_read, and has_imm.

Verification
REQ-021 The bench SHALL cover: reset mid-S_IMM (LDD word accepted, reset) -> next cycle idex_valid=0, state S_OP; the following ADD decodes normally.
REQ-022 The bench SHALL cover: R2=0x1234, R3=0x0011, ADD R1,R2,R3 at pc=0x0040 -> one cycle later valid=1, rs1_data=0x1234, rs2_data=0x0011, rdst=1, imm=0.
REQ-023 The bench SHALL cover: LDD R4,R2 then imm 0x0008 -> bubble, then valid=1, opcode=5'b10010, imm=0x0008, mem_read=1, pc of the first word.
REQ-024 The bench SHALL cover: LDD R4 in ID/EX, next ADD R5,R4,R1 -> if_stall=1 for exactly one cycle, one bubble, then ADD issues.
REQ-025 The bench SHALL cover: flush in S_IMM -> bubble, state S_OP; next word decoded as opcode; flush together with hazard -> if_stall=0.
REQ-026 The bench SHALL cover: WB writes R2=0xBEEF in the same cycle ADD reads R2 -> rs1_data=0xBEEF.
